// File: rtl/lut_config_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lut_config_ctrl
//  Description : Serialises a WIDTH-bit configuration word, MSB first, into a
//                shift-register LUT configuration chain. Accepts words through
//                a valid/ready handshake, supports mid-load abort, and drives
//                a select bus that is frozen while a load is in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_config_ctrl #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic             cfg_abort,
  input  logic [SEL_W-1:0] sel_in,
  output logic             lut_config_in,
  output logic             lut_shift_en,
  output logic [SEL_W-1:0] lut_select,
  output logic             busy,
  output logic             done,
  output logic             lut_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;

  // Next-state and datapath: load on handshake, shift while in SHIFT,
  // abort takes priority over completion on the final bit.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = sel_in;
        if (cfg_valid) begin
          state_d = ST_SHIFT;
          shreg_d = cfg_data;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (cfg_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_last_bit) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  // Outputs decode the registered state only. cfg_ready is additionally
  // qualified by reset_n so that it stays low while reset is held.
  assign cfg_ready     = reset_n && (state_q == ST_IDLE);
  assign lut_shift_en  = (state_q == ST_SHIFT);
  assign lut_config_in = lut_shift_en && shreg_q[WIDTH-1];
  assign done          = (state_q == ST_DONE);
  assign busy          = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign lut_select    = sel_q;
  assign lut_valid     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_config_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_config_ctrl
//  Description : Directed self-checking bench for lut_config_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_config_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ready;
  logic        cfg_abort = 1'b0;
  logic [3:0]  sel_in = '0;
  logic        lut_config_in;
  logic        lut_shift_en;
  logic [3:0]  lut_select;
  logic        busy;
  logic        done;
  logic        lut_valid;

  int n_assert = 0;
  int n_fail   = 0;

  lut_config_ctrl #(.WIDTH(16), .SEL_W(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .cfg_abort     (cfg_abort),
    .sel_in        (sel_in),
    .lut_config_in (lut_config_in),
    .lut_shift_en  (lut_shift_en),
    .lut_select    (lut_select),
    .busy          (busy),
    .done          (done),
    .lut_valid     (lut_valid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the 16 SHIFT cycles of one load against a hand-written bit sequence.
  task automatic check_shift(input string tag, input logic [15:0] seq);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_en"},  lut_shift_en, 1);
      check({tag, "_bit"}, lut_config_in, seq[15-i]);
      check({tag, "_nodone"}, done, 0);
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  cfg_ready, 0);
    check({tag, "_shift"},  lut_shift_en, 0);
    check({tag, "_cin"},    lut_config_in, 0);
    check({tag, "_sel"},    lut_select, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_valid"},  lut_valid, 0);
    check({tag, "_busy"},   busy, 0);
  endtask

  initial begin
    // ---------------- asynchronous reset ----------------
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst");
    step();
    step();
    check_reset_outputs("rst_held");

    // ---------------- basic load 16'hA5C3, handshake on first edge after release
    reset_n   = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'hA5C3;
    #1 check("rdy_after_rst", cfg_ready, 1);
    step();                                   // handshake edge
    cfg_valid = 1'b0;
    cfg_data  = 16'h0000;
    check("a5_busy", busy, 1);
    check("a5_ready", cfg_ready, 0);
    check("a5_valid_clr", lut_valid, 0);
    check_shift("a5", 16'b1010_0101_1100_0011);
    check("a5_done", done, 1);                // 17 cycles after handshake
    check("a5_done_shift", lut_shift_en, 0);
    check("a5_done_ready", cfg_ready, 0);
    check("a5_done_busy", busy, 1);
    check("a5_done_valid", lut_valid, 0);
    step();
    check("a5_idle_done", done, 0);
    check("a5_idle_valid", lut_valid, 1);
    check("a5_idle_ready", cfg_ready, 1);
    check("a5_idle_busy", busy, 0);

    // ---------------- back-to-back with cfg_valid held; abort during DONE ignored
    cfg_valid = 1'b1;
    cfg_data  = 16'hFFFF;
    step();                                   // first handshake
    cfg_data  = 16'h0001;                     // no effect until next handshake
    check_shift("ff", 16'hFFFF);
    check("ff_done", done, 1);
    cfg_abort = 1'b1;
    step();                                   // DONE -> IDLE despite abort
    cfg_abort = 1'b0;
    check("ff_valid", lut_valid, 1);
    check("ff_idle_ready", cfg_ready, 1);
    check("ff_idle_shift", lut_shift_en, 0);
    step();                                   // second handshake
    cfg_valid = 1'b0;
    check("b2b_valid_clr", lut_valid, 0);
    check_shift("01", 16'h0001);
    check("01_done", done, 1);
    step();
    check("01_valid", lut_valid, 1);

    // ---------------- abort at SHIFT cycle 5
    cfg_valid = 1'b1;
    cfg_data  = 16'h1234;
    step();
    cfg_valid = 1'b0;
    repeat (4) step();                        // now in SHIFT cycle 5
    check("ab5_in_shift", lut_shift_en, 1);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("ab5_shift", lut_shift_en, 0);
    check("ab5_ready", cfg_ready, 1);
    check("ab5_busy", busy, 0);
    check("ab5_valid", lut_valid, 0);
    for (int i = 0; i < 20; i++) begin
      check("ab5_nodone", done, 0);
      step();
    end
    check("ab5_valid_late", lut_valid, 0);

    // ---------------- abort coincident with the final bit
    cfg_valid = 1'b1;
    cfg_data  = 16'hFFFF;
    step();
    cfg_valid = 1'b0;
    repeat (15) step();                       // counter = 15
    check("ab15_in_shift", lut_shift_en, 1);
    check("ab15_last_bit", lut_config_in, 1);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("ab15_done", done, 0);
    check("ab15_shift", lut_shift_en, 0);
    check("ab15_busy", busy, 0);
    check("ab15_ready", cfg_ready, 1);
    check("ab15_valid", lut_valid, 0);
    step();
    check("ab15_done_late", done, 0);

    // ---------------- abort in IDLE ignored
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("abidle_ready", cfg_ready, 1);
    check("abidle_busy", busy, 0);

    // ---------------- select frozen during a load
    sel_in = 4'h3;
    step();
    check("sel_idle", lut_select, 4'h3);
    cfg_valid = 1'b1;
    cfg_data  = 16'h0F0F;
    step();
    cfg_valid = 1'b0;
    sel_in    = 4'hC;
    check("sel_shift_first", lut_select, 4'h3);
    repeat (16) step();
    check("sel_done_state", done, 1);
    check("sel_done", lut_select, 4'h3);
    step();
    check("sel_first_idle", lut_select, 4'h3);
    check("sel_first_idle_valid", lut_valid, 1);
    step();
    check("sel_updated", lut_select, 4'hC);

    // ---------------- reset pulsed at SHIFT cycle 8
    cfg_valid = 1'b1;
    cfg_data  = 16'hFFFF;
    step();
    cfg_valid = 1'b0;
    repeat (7) step();                        // SHIFT cycle 8
    check("rs8_in_shift", lut_shift_en, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rs8");
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("rs8_nodone", done, 0);
      step();
    end
    check("rs8_valid", lut_valid, 0);
    check("rs8_ready", cfg_ready, 1);
    check("rs8_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
